// File: rtl/micro_sequencer.sv
// micro_sequencer: microprogram address sequencer running fetch, dispatch, exec and halt/timeout handling
module micro_sequencer #(
  parameter logic [15:0] FETCH_BASE = 16'h0010,
  parameter int          MAX_STEPS  = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [5:0]  Opcode,
  input  logic [15:0] CU_entry,
  input  logic [1:0]  u_seq,
  input  logic [15:0] u_next,
  input  logic        flag_z,
  input  logic        flag_c,
  output logic [15:0] upc,
  output logic        ir_load,
  output logic        running,
  output logic        halted,
  output logic        illegal,
  output logic        timeout,
  output logic [15:0] instr_cnt
);
  localparam logic [2:0] S_IDLE = 3'd0, S_FETCH = 3'd1, S_DISPATCH = 3'd2, S_EXEC = 3'd3, S_HALT = 3'd4;
  localparam logic [1:0] SEQ_INC = 2'b00, SEQ_JUMP = 2'b01, SEQ_COND = 2'b10, SEQ_END = 2'b11;
  logic [2:0]  r_state;
  logic [15:0] r_upc, r_instr_cnt;
  logic [7:0]  r_step_cnt;
  logic        r_illegal, r_timeout;
  logic        w_cond, w_last;
  logic [15:0] w_inc, w_exec_upc;
  always_comb begin
    w_inc = r_upc + 16'd1;
    w_cond = (Opcode[5:1] == 5'b01011) ? flag_z :
             (Opcode[5:1] == 5'b01100) ? ~flag_z :
             (Opcode[5:1] == 5'b01101) ? (flag_c & ~flag_z) :
             (Opcode[5:1] == 5'b01110) ? flag_c :
             (Opcode[5:1] == 5'b01111) ? ~flag_c :
             (Opcode[5:1] == 5'b10000) ? (~flag_c | flag_z) :
             (Opcode[5:1] == 5'b10001);
    w_exec_upc = (u_seq == SEQ_JUMP || (u_seq == SEQ_COND && w_cond)) ? u_next : w_inc;
    w_last = r_step_cnt == 8'(MAX_STEPS - 1);
  end
  assign upc       = r_upc;
  assign ir_load   = (r_state == S_FETCH) && (u_seq == SEQ_END);
  assign running   = (r_state == S_FETCH) || (r_state == S_DISPATCH) || (r_state == S_EXEC);
  assign halted    = r_state == S_HALT;
  assign illegal   = r_illegal;
  assign timeout   = r_timeout;
  assign instr_cnt = r_instr_cnt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_upc       <= 16'h0000;
      r_instr_cnt <= 16'h0000;
      r_step_cnt  <= 8'd0;
      r_illegal   <= 1'b0;
      r_timeout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start) begin
          r_state <= S_FETCH;
          r_upc   <= FETCH_BASE;
        end
        S_FETCH: begin
          r_state <= (u_seq == SEQ_END) ? S_DISPATCH : S_FETCH;
          r_upc   <= (u_seq == SEQ_END) ? r_upc : (u_seq == SEQ_JUMP) ? u_next : w_inc;
        end
        S_DISPATCH: begin
          r_state    <= (CU_entry != 16'h0000) ? S_EXEC : S_HALT;
          r_upc      <= (CU_entry != 16'h0000) ? CU_entry : r_upc;
          r_illegal  <= (CU_entry == 16'h0000) && (Opcode != 6'b111110);
          r_step_cnt <= 8'd0;
        end
        S_EXEC: begin
          r_step_cnt <= r_step_cnt + 8'd1;
          // END wins over the step limit on the final allowed cycle
          if (u_seq == SEQ_END) begin
            r_state     <= S_FETCH;
            r_upc       <= FETCH_BASE;
            r_instr_cnt <= r_instr_cnt + 16'd1;
          end else if (w_last) begin
            r_state   <= S_HALT;
            r_timeout <= 1'b1;
          end else begin
            r_upc <= w_exec_upc;
          end
        end
        S_HALT: if (start) begin
          r_state   <= S_FETCH;
          r_upc     <= FETCH_BASE;
          r_illegal <= 1'b0;
          r_timeout <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: directed scoreboard bench for the microprogram sequencer
module tb_micro_sequencer;
  localparam logic [1:0] INC = 2'b00, JUMP = 2'b01, COND = 2'b10, ENDW = 2'b11;
  logic        clk = 1'b0, rst_n = 1'b0, start = 1'b0, flag_z = 1'b0, flag_c = 1'b0;
  logic [5:0]  Opcode = 6'd0;
  logic [15:0] CU_entry = 16'h0000, u_next = 16'h0000;
  logic [1:0]  u_seq = INC;
  logic [15:0] upc, instr_cnt;
  logic        ir_load, running, halted, illegal, timeout;
  logic [15:0] e_cnt = 16'h0000;
  string       q_tag[$];
  logic [36:0] q_val[$];
  int          n_cmp = 0, n_bad = 0;
  micro_sequencer #(.FETCH_BASE(16'h0010), .MAX_STEPS(16)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .Opcode(Opcode), .CU_entry(CU_entry),
    .u_seq(u_seq), .u_next(u_next), .flag_z(flag_z), .flag_c(flag_c), .upc(upc),
    .ir_load(ir_load), .running(running), .halted(halted), .illegal(illegal),
    .timeout(timeout), .instr_cnt(instr_cnt)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask
  task automatic want(input string tag, input logic [15:0] u, input logic irl, input logic run,
                      input logic hlt, input logic ill, input logic to);
    q_tag.push_back(tag);
    q_val.push_back({u, irl, run, hlt, ill, to, e_cnt});
  endtask
  task automatic check();
    string       t;
    logic [36:0] e, o;
    #1;
    o = {upc, ir_load, running, halted, illegal, timeout, instr_cnt};
    t = q_tag.pop_front();
    e = q_val.pop_front();
    n_cmp++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s observed upc=%h irl/run/hlt/ill/to=%b cnt=%h expected upc=%h irl/run/hlt/ill/to=%b cnt=%h",
             t, o[36:21], o[20:16], o[15:0], e[36:21], e[20:16], e[15:0]);
    end
  endtask
  task automatic step(input string tag, input logic [1:0] s, input logic [15:0] nxt,
                      input logic [15:0] u, input logic irl, input logic run,
                      input logic hlt, input logic ill, input logic to);
    u_seq  = s;
    u_next = nxt;
    want(tag, u, irl, run, hlt, ill, to);
    check();
    tick();
  endtask
  task automatic do_fetch(input string tag, input logic [15:0] entry);
    CU_entry = entry;
    step({tag, "_f0"}, INC, 16'h0000, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step({tag, "_f1"}, COND, 16'h0BAD, 16'h0011, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step({tag, "_f2"}, ENDW, 16'h0BAD, 16'h0012, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step({tag, "_dp"}, INC, 16'h0BAD, 16'h0012, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
  endtask
  task automatic ex_end(input string tag, input logic [15:0] u);
    step(tag, ENDW, 16'h0BAD, u, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    e_cnt = e_cnt + 16'd1;
  endtask
  task automatic cond_instr(input string tag, input logic [5:0] opc, input logic z, input logic c,
                            input logic [15:0] target);
    Opcode = opc;
    flag_z = z;
    flag_c = c;
    do_fetch(tag, 16'h0570);
    step({tag, "_c"}, COND, 16'h05A0, 16'h0570, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_end({tag, "_e"}, target);
  endtask
  initial begin
    @(negedge clk);
    want("reset", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    step("idle_noise", ENDW, 16'h1234, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b1;
    step("idle_start", INC, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    do_fetch("mov", 16'h0400);
    ex_end("mov_end", 16'h0400);
    do_fetch("add", 16'h0460);
    start = 1'b1;
    step("add_inc", INC, 16'h0BAD, 16'h0460, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    start = 1'b0;
    ex_end("add_end", 16'h0461);
    cond_instr("eq_t", 6'b010111, 1'b1, 1'b0, 16'h05A0);
    cond_instr("eq_f", 6'b010111, 1'b0, 1'b0, 16'h0571);
    cond_instr("hi_f", 6'b011011, 1'b1, 1'b1, 16'h0571);
    cond_instr("jmp", 6'b100011, 1'b0, 1'b0, 16'h05A0);
    cond_instr("lo_t", 6'b011110, 1'b1, 1'b0, 16'h05A0);
    cond_instr("none", 6'b000000, 1'b1, 1'b1, 16'h0571);
    CU_entry = 16'h0570;
    step("fj_f0", JUMP, 16'h0020, 16'h0010, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("fj_f1", ENDW, 16'h0BAD, 16'h0020, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step("fj_dp", INC, 16'h0BAD, 16'h0020, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("wrap_j", JUMP, 16'hFFFF, 16'h0570, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("wrap_i", INC, 16'h0BAD, 16'hFFFF, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_end("wrap_e", 16'h0000);
    Opcode = 6'b111110;
    do_fetch("hlt", 16'h0000);
    step("hlt_st", INC, 16'h0BAD, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    step("hlt_hold", JUMP, 16'h0BAD, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b1;
    step("hlt_go", ENDW, 16'h0BAD, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    start = 1'b0;
    Opcode = 6'b000101;
    do_fetch("ill", 16'h0000);
    step("ill_st", JUMP, 16'h0BAD, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b1;
    step("ill_go", INC, 16'h0BAD, 16'h0012, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0);
    start = 1'b0;
    do_fetch("to", 16'h0600);
    for (int k = 0; k < 16; k++)
      step($sformatf("to_x%0d", k), INC, 16'h0BAD, 16'h0600 + 16'(k), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("to_hold", INC, 16'h0BAD, 16'h060F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    start = 1'b1;
    step("to_go", INC, 16'h0BAD, 16'h060F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
    start = 1'b0;
    do_fetch("lim", 16'h0600);
    for (int k = 0; k < 15; k++)
      step($sformatf("lim_x%0d", k), INC, 16'h0BAD, 16'h0600 + 16'(k), 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    ex_end("lim_end", 16'h060F);
    do_fetch("rst", 16'h0460);
    step("rst_x0", INC, 16'h0BAD, 16'h0460, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst_x1", INC, 16'h0BAD, 16'h0461, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step("rst_x2", INC, 16'h0BAD, 16'h0462, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    u_seq = INC;
    want("rst_pre", 16'h0463, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    check();
    rst_n = 1'b0;
    e_cnt = 16'h0000;
    want("rst_async", 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
